// File: rtl/lcd_mmio_driver_pkg.sv
// rtl/lcd_mmio_driver_pkg.sv - shared types, register offsets and opcodes for the LCD MMIO driver
package lcd_mmio_driver_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_WAIT
  } lcd_state_e;

  localparam logic [1:0] OFF_DATA   = 2'd0;
  localparam logic [1:0] OFF_CMD    = 2'd1;
  localparam logic [1:0] OFF_STATUS = 2'd2;
  localparam logic [1:0] OFF_FLUSH  = 2'd3;

  localparam int STAT_BUSY_BIT  = 0;
  localparam int STAT_FULL_BIT  = 1;
  localparam int STAT_OVF_BIT   = 2;
  localparam int STAT_COUNT_LSB = 8;

  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_HOME     = 8'h02;
  localparam logic [7:0] CMD_HOME_ALT = 8'h03;

  // Clear and home need the long execution wait; only when sent as commands.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] b);
    return !rs && (b == CMD_CLEAR || b == CMD_HOME || b == CMD_HOME_ALT);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_mmio_driver_fifo.sv
// rtl/lcd_mmio_driver_fifo.sv - pointer+count synchronous FIFO holding {rs, byte} entries
module lcd_mmio_driver_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8,
  parameter int CNTW  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNTW-1:0]  count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count == CNTW'(DEPTH));
  assign empty    = (count == '0);
  // Fullness is judged before any same-cycle pop, so a push into a full FIFO drops.
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CNTW'(push_ok) - CNTW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/lcd_mmio_driver.sv
// rtl/lcd_mmio_driver.sv - MMIO LCD controller replaying queued bytes with HD44780 timing; LCD_SIM_PRINT_EN adds a sim-only char log
module lcd_mmio_driver
  import lcd_mmio_driver_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int T_SETUP     = 2,
  parameter int T_PULSE     = 12,
  parameter int T_HOLD      = 2,
  parameter int T_EXEC      = 2000,
  parameter int T_EXEC_LONG = 80000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [1:0]  wr_addr,
  input  logic [7:0]  wr_data,
  input  logic [1:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic [7:0]  lcd_data,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_e,
  output logic        busy
);

  localparam int T_MAX = max_int(max_int(max_int(T_SETUP, T_PULSE), max_int(T_HOLD, T_EXEC)),
                                 T_EXEC_LONG);
  localparam int CW    = $clog2(T_MAX + 1);
  localparam int CNTW  = $clog2(FIFO_DEPTH + 1);

  lcd_state_e      state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            pop;
  logic            load;
  logic            push_req;
  logic            flush_req;
  logic            overflow;
  logic [8:0]      fifo_head;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CNTW-1:0] fifo_count;
  logic [31:0]     status;

  assign push_req  = wr_en && (wr_addr == OFF_DATA || wr_addr == OFF_CMD);
  assign flush_req = wr_en && (wr_addr == OFF_FLUSH);

  lcd_mmio_driver_fifo #(
    .WIDTH (9),
    .DEPTH (FIFO_DEPTH),
    .CNTW  (CNTW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_req),
    .push_data ({(wr_addr == OFF_DATA), wr_data}),
    .pop       (pop),
    .flush     (flush_req),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Each timed state loads N-1 on entry and leaves when the counter reads 0.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pop       = 1'b0;
    load      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          load      = 1'b1;
          state_nxt = ST_SETUP;
          cnt_nxt   = CW'(T_SETUP - 1);
        end
      end
      ST_SETUP: begin
        if (cnt == '0) begin
          state_nxt = ST_PULSE;
          cnt_nxt   = CW'(T_PULSE - 1);
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      ST_PULSE: begin
        if (cnt == '0) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = CW'(T_HOLD - 1);
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      ST_HOLD: begin
        if (cnt == '0) begin
          state_nxt = ST_WAIT;
          cnt_nxt   = is_long_cmd(lcd_rs, lcd_data) ? CW'(T_EXEC_LONG - 1) : CW'(T_EXEC - 1);
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      ST_WAIT: begin
        if (cnt == '0) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lcd_data <= '0;
      lcd_rs   <= 1'b0;
    end else if (load) begin
      lcd_rs   <= fifo_head[8];
      lcd_data <= fifo_head[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (flush_req) begin
      overflow <= 1'b0;
    end else if (push_req && fifo_full) begin
      overflow <= 1'b1;
    end
  end

  // E is decoded straight from the state register so an async reset drops it at once.
  assign lcd_e  = (state == ST_PULSE);
  assign lcd_rw = 1'b0;
  assign busy   = (state != ST_IDLE) || !fifo_empty;

  always_comb begin
    status                            = '0;
    status[STAT_BUSY_BIT]             = busy;
    status[STAT_FULL_BIT]             = fifo_full;
    status[STAT_OVF_BIT]              = overflow;
    status[STAT_COUNT_LSB +: 8]       = 8'(fifo_count);
  end

  assign rd_data = (rd_addr == OFF_STATUS) ? status : 32'h0;

`ifdef LCD_SIM_PRINT_EN
  always @(negedge lcd_e) begin
    if (rst_n && lcd_rs) $write("%c", lcd_data);
  end
`else
`endif

endmodule

// File: tb/tb_lcd_mmio_driver.sv
// tb/tb_lcd_mmio_driver.sv - directed self-checking bench for lcd_mmio_driver
module tb_lcd_mmio_driver;

  localparam logic [1:0] A_DATA   = 2'd0;
  localparam logic [1:0] A_CMD    = 2'd1;
  localparam logic [1:0] A_RSVD   = 2'd2;
  localparam logic [1:0] A_STATUS = 2'd2;
  localparam logic [1:0] A_FLUSH  = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [1:0]  rd_addr;
  logic [31:0] rd_data;
  logic [7:0]  lcd_data;
  logic        lcd_rs;
  logic        lcd_rw;
  logic        lcd_e;
  logic        busy;

  int tests_run    = 0;
  int tests_failed = 0;
  int e_rises      = 0;
  logic [8:0] strobes [$];

  lcd_mmio_driver #(
    .FIFO_DEPTH  (8),
    .T_SETUP     (2),
    .T_PULSE     (3),
    .T_HOLD      (2),
    .T_EXEC      (5),
    .T_EXEC_LONG (40)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .lcd_data (lcd_data),
    .lcd_rs   (lcd_rs),
    .lcd_rw   (lcd_rw),
    .lcd_e    (lcd_e),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge lcd_e) e_rises++;
  always @(negedge lcd_e) if (rst_n) strobes.push_back({lcd_rs, lcd_data});

  // Returns on the falling clock edge right after the write was taken.
  task automatic write_reg(input logic [1:0] a, input logic [7:0] d);
    wr_addr = a;
    wr_data = d;
    wr_en   = 1'b1;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL wait_idle: busy=%b still set after %0d cycles, required 0", busy, budget);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = A_STATUS;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({lcd_e, lcd_rs, lcd_rw, busy, lcd_data} !== 12'h0 || rd_data !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: e=%b rs=%b rw=%b busy=%b data=%h status=%h, required all 0",
               lcd_e, lcd_rs, lcd_rw, busy, lcd_data, rd_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reserved_and_reads;
    write_reg(A_RSVD, 8'h77);
    tests_run++;
    if (busy !== 1'b0 || rd_data !== 32'h0) begin
      tests_failed++;
      $display("FAIL reserved_write: busy=%b status=%h, required 0/00000000", busy, rd_data);
    end
    rd_addr = A_CMD;
    write_reg(A_DATA, 8'h20);
    tests_run++;
    if (rd_data !== 32'h0) begin
      tests_failed++;
      $display("FAIL nonstatus_read: rd_data=%h, required 00000000", rd_data);
    end
    rd_addr = A_STATUS;
    wait_idle(100);
  endtask

  task automatic test_single_data;
    logic e_exp, b_exp;
    strobes.delete();
    write_reg(A_DATA, 8'h41);
    for (int i = 1; i <= 15; i++) begin
      e_exp = (i >= 4 && i <= 6);
      b_exp = (i <= 13);
      tests_run++;
      if (lcd_e !== e_exp || busy !== b_exp) begin
        tests_failed++;
        $display("FAIL single_timing cyc%0d: e=%b busy=%b, required e=%b busy=%b",
                 i, lcd_e, busy, e_exp, b_exp);
      end
      if (i == 2) begin
        tests_run++;
        if (lcd_rs !== 1'b1 || lcd_data !== 8'h41) begin
          tests_failed++;
          $display("FAIL single_latch: rs=%b data=%h, required 1/41", lcd_rs, lcd_data);
        end
      end
      @(negedge clk);
    end
    tests_run++;
    if (strobes.size() != 1 || strobes[0] !== 9'h141) begin
      tests_failed++;
      $display("FAIL single_strobe: n=%0d, required 1 strobe of 141", strobes.size());
    end
  endtask

  task automatic measure_cmd(input logic [7:0] op, input int busy_exp);
    int n = 0;
    write_reg(A_CMD, op);
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    tests_run++;
    if (n != busy_exp || lcd_rs !== 1'b0 || lcd_data !== op) begin
      tests_failed++;
      $display("FAIL cmd_%h_wait: busy_cycles=%0d rs=%b data=%h, required %0d/0/%h",
               op, n, lcd_rs, lcd_data, busy_exp, op);
    end
  endtask

  task automatic test_cmd_exec;
    measure_cmd(8'h01, 1 + 2 + 3 + 2 + 40);
    measure_cmd(8'h38, 1 + 2 + 3 + 2 + 5);
    measure_cmd(8'h03, 1 + 2 + 3 + 2 + 40);
  endtask

  task automatic test_overflow;
    strobes.delete();
    write_reg(A_DATA, 8'h30);
    for (int i = 1; i <= 9; i++) write_reg(A_DATA, 8'(8'h30 + i));
    tests_run++;
    if (rd_data !== 32'h0000_0807) begin
      tests_failed++;
      $display("FAIL overflow_status: status=%h, required 00000807", rd_data);
    end
    wait_idle(400);
    tests_run++;
    if (strobes.size() != 9) begin
      tests_failed++;
      $display("FAIL overflow_count: strobes=%0d, required 9", strobes.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        tests_run++;
        if (strobes[i] !== 9'(9'h130 + i)) begin
          tests_failed++;
          $display("FAIL overflow_order[%0d]: %h, required %h", i, strobes[i], 9'(9'h130 + i));
        end
      end
    end
    tests_run++;
    if (rd_data !== 32'h0000_0004) begin
      tests_failed++;
      $display("FAIL overflow_sticky: status=%h, required 00000004", rd_data);
    end
    write_reg(A_FLUSH, 8'h00);
    tests_run++;
    if (rd_data !== 32'h0) begin
      tests_failed++;
      $display("FAIL flush_clears_ovf: status=%h, required 00000000", rd_data);
    end
  endtask

  task automatic test_flush_midpulse;
    int rises0;
    strobes.delete();
    rises0 = e_rises;
    write_reg(A_DATA, 8'h48);
    write_reg(A_DATA, 8'h49);
    repeat (2) @(negedge clk);
    tests_run++;
    if (lcd_e !== 1'b1) begin
      tests_failed++;
      $display("FAIL flush_in_pulse: e=%b, required 1", lcd_e);
    end
    write_reg(A_FLUSH, 8'h00);
    tests_run++;
    if (rd_data !== 32'h0000_0001) begin
      tests_failed++;
      $display("FAIL flush_status: status=%h, required 00000001", rd_data);
    end
    wait_idle(100);
    repeat (10) @(negedge clk);
    tests_run++;
    if (strobes.size() != 1 || strobes[0] !== 9'h148 || e_rises != rises0 + 1) begin
      tests_failed++;
      $display("FAIL flush_drop: strobes=%0d rises=%0d, required 1 strobe of 148",
               strobes.size(), e_rises - rises0);
    end
  endtask

  task automatic test_async_reset;
    int rises0;
    write_reg(A_DATA, 8'h55);
    repeat (3) @(negedge clk);
    tests_run++;
    if (lcd_e !== 1'b1) begin
      tests_failed++;
      $display("FAIL areset_pre: e=%b, required 1", lcd_e);
    end
    rises0 = e_rises;
    #1 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({lcd_e, lcd_rs, busy, lcd_data} !== 11'h0 || rd_data !== 32'h0) begin
      tests_failed++;
      $display("FAIL areset_now: e=%b rs=%b busy=%b data=%h status=%h, required all 0",
               lcd_e, lcd_rs, busy, lcd_data, rd_data);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    tests_run++;
    if (e_rises != rises0 || rd_data !== 32'h0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL areset_after: extra_rises=%0d status=%h busy=%b, required 0/00000000/0",
               e_rises - rises0, rd_data, busy);
    end
  endtask

  initial begin
    test_reset();
    test_reserved_and_reads();
    test_single_data();
    test_cmd_exec();
    test_overflow();
    test_flush_midpulse();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
